// File: rtl/matmul_prod_seq_if.sv
// Operand-load, run-control and product-stream bundle of the matrix-multiplier product sequencer.
// The master drives loads and start; the slave (the sequencer) returns status and the product stream.
interface matmul_prod_seq_if #(
    parameter int AW = 1
);
    logic            load_we;
    logic            load_sel;
    logic [2*AW-1:0] load_addr;
    logic [31:0]     load_data;
    logic            start;
    logic            busy;
    logic            done;
    logic [31:0]     prod;
    logic            prod_valid;
    logic [AW-1:0]   row_idx;
    logic [AW-1:0]   col_idx;
    logic            sat;

    modport master (
        output load_we, load_sel, load_addr, load_data, start,
        input  busy, done, prod, prod_valid, row_idx, col_idx, sat
    );

    modport slave (
        input  load_we, load_sel, load_addr, load_data, start,
        output busy, done, prod, prod_valid, row_idx, col_idx, sat
    );
endinterface

// File: rtl/matmul_prod_seq.sv
// Operand store and product sequencer: streams A[i][k]*B[k][j] (Q11.21, saturated) row-major,
// N products per C element, each group followed by one idle cycle for the downstream accumulator.
module matmul_prod_seq #(
    parameter int N  = 2,
    parameter int AW = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    matmul_prod_seq_if.slave bus
);
    localparam int            DEPTH = 1 << (2 * AW);
    localparam logic [AW-1:0] LAST  = AW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

    state_t        state_q;
    logic [31:0]   a_q [DEPTH];
    logic [31:0]   b_q [DEPTH];
    logic [AW-1:0] i_q, j_q, k_q;
    logic [AW-1:0] row_q, col_q;
    logic [31:0]   prod_q;
    logic          prod_valid_q, busy_q, done_q, sat_q;

    logic [31:0]   a_op, b_op;
    logic [42:0]   prod_hi;
    logic          sat_d;
    logic [31:0]   prod_d;

    // Bits [63:21] of the full Q22.42 product; the arithmetic shift truncates toward minus infinity.
    // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
    always_comb begin
        a_op    = a_q[{i_q, k_q}];
        b_op    = b_q[{k_q, j_q}];
        prod_hi = 43'(($signed({{32{a_op[31]}}, a_op}) * $signed({{32{b_op[31]}}, b_op})) >>> 21);
        sat_d   = (prod_hi[42:31] != {12{prod_hi[31]}});
        if (!sat_d)          prod_d = prod_hi[31:0];
        else if (prod_hi[42]) prod_d = 32'h8000_0000;
        else                 prod_d = 32'h7FFF_FFFF;
    end

    // NOTE: the operand arrays are reset explicitly because a cleared store is part of the reset state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int n = 0; n < DEPTH; n++) begin
                a_q[n] <= '0;
                b_q[n] <= '0;
            end
        end else if (bus.load_we && !busy_q) begin
            if (bus.load_sel) b_q[bus.load_addr] <= bus.load_data;
            else              a_q[bus.load_addr] <= bus.load_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            i_q          <= '0;
            j_q          <= '0;
            k_q          <= '0;
            row_q        <= '0;
            col_q        <= '0;
            prod_q       <= '0;
            prod_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sat_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q <= RUN;
                        i_q     <= '0;
                        j_q     <= '0;
                        k_q     <= '0;
                        sat_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    prod_q       <= prod_d;
                    prod_valid_q <= 1'b1;
                    row_q        <= i_q;
                    col_q        <= j_q;
                    if (sat_d) sat_q <= 1'b1;
                    if (k_q == LAST) state_q <= GAP;
                    else             k_q     <= k_q + AW'(1);
                end
                GAP: begin
                    // The accumulator clears during this cycle, so no product may be presented.
                    prod_valid_q <= 1'b0;
                    k_q          <= '0;
                    if (j_q != LAST) begin
                        j_q     <= j_q + AW'(1);
                        state_q <= RUN;
                    end else begin
                        j_q <= '0;
                        if (i_q == LAST) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            i_q     <= i_q + AW'(1);
                            state_q <= RUN;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.prod       = prod_q;
    assign bus.prod_valid = prod_valid_q;
    assign bus.row_idx    = row_q;
    assign bus.col_idx    = col_q;
    assign bus.sat        = sat_q;
endmodule

// File: tb/tb_matmul_prod_seq.sv
// Self-checking bench for matmul_prod_seq: scoreboard of expected products, table of single-product
// vectors, per-cycle timing checks, write/start protection while busy, and reset mid-run.
module tb_matmul_prod_seq;
    localparam int N  = 2;
    localparam int AW = 1;
    localparam int NP = N * N * N;

    typedef struct {
        logic [31:0]   prod;
        logic [AW-1:0] row;
        logic [AW-1:0] col;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_prod;
        logic        exp_sat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   flags_seen = 0;
    exp_t sb[$];
    logic [31:0] a_m [N*N];
    logic [31:0] b_m [N*N];

    matmul_prod_seq_if #(.AW(AW)) bus ();

    matmul_prod_seq #(.N(N), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference multiply: 64-bit product, floor shift, clamp to the signed 32-bit range.
    function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = (longint'($signed(a)) * longint'($signed(b))) >>> 21;
        if (p > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (p < -64'sd2147483648) return 32'h8000_0000;
        return p[31:0];
    endfunction

    task automatic push_model();
        exp_t e;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                for (int k = 0; k < N; k++) begin
                    e.prod = model_mul(a_m[i*N+k], b_m[k*N+j]);
                    e.row  = AW'(i);
                    e.col  = AW'(j);
                    sb.push_back(e);
                end
    endtask

    task automatic push_list(input logic [31:0] vals [NP]);
        exp_t e;
        for (int n = 0; n < NP; n++) begin
            e.prod = vals[n];
            e.row  = AW'((n / N) / N);
            e.col  = AW'((n / N) % N);
            sb.push_back(e);
        end
    endtask

    task automatic load(input logic sel, input int addr, input logic [31:0] d);
        @(negedge clk);
        bus.load_we   = 1'b1;
        bus.load_sel  = sel;
        bus.load_addr = (2*AW)'(addr);
        bus.load_data = d;
        @(negedge clk);
        bus.load_we = 1'b0;
        if (sel) b_m[addr] = d;
        else     a_m[addr] = d;
    endtask

    task automatic clear_ops();
        for (int n = 0; n < N*N; n++) begin
            load(1'b0, n, 32'h0);
            load(1'b1, n, 32'h0);
        end
    endtask

    // One full run with cycle-exact checks of prod_valid, done and busy; optionally hammers
    // load_we and start while busy.
    task automatic run(input bit disturb);
        int  fb;
        logic exp_v;
        fb = flags_seen;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("busy_on", bus.busy, 1);
        check("sat_clr", bus.sat, 0);
        check("pv_e0", bus.prod_valid, 0);
        for (int c = 1; c <= 13; c++) begin
            @(posedge clk);
            #1;
            exp_v = (c <= 12) && (c % 3 != 0);
            check($sformatf("pv_c%0d", c), bus.prod_valid, exp_v);
            check($sformatf("done_c%0d", c), bus.done, c == 12);
            check($sformatf("busy_c%0d", c), bus.busy, c < 13);
            if (disturb && c <= 10) begin
                bus.load_we   = 1'b1;
                bus.load_sel  = c[0];
                bus.load_addr = (2*AW)'(c);
                bus.load_data = 32'h5A5A_0000 ^ c;
                bus.start     = c[0];
            end else begin
                bus.load_we = 1'b0;
                bus.start   = 1'b0;
            end
        end
        check("flags", flags_seen - fb, N*N);
        check("sb_drain", sb.size(), 0);
    endtask

    // Product monitor, plus a 2-term accumulator model summing each group of N products.
    initial begin
        int   grp = 0;
        logic [31:0] act_acc = 0, exp_acc = 0;
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                grp = 0;
                act_acc = 0;
                exp_acc = 0;
            end else if (bus.prod_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_prod: got %h with nothing expected at %0t", bus.prod, $time);
                end else begin
                    e = sb.pop_front();
                    check("prod", bus.prod, e.prod);
                    check("row_idx", bus.row_idx, e.row);
                    check("col_idx", bus.col_idx, e.col);
                    act_acc += bus.prod;
                    exp_acc += e.prod;
                    grp++;
                    if (grp == N) begin
                        check("acc_dot", act_acc, exp_acc);
                        flags_seen++;
                        grp = 0;
                        act_acc = 0;
                        exp_acc = 0;
                    end
                end
            end
        end
    end

    initial begin
        vec_t        vecs [7];
        logic [31:0] ident [NP];
        logic [31:0] single [NP];

        vecs[0] = '{32'hFFE0_0000, 32'h0010_0000, 32'hFFF0_0000, 1'b0};
        vecs[1] = '{32'h0000_0001, 32'h0010_0000, 32'h0000_0000, 1'b0};
        vecs[2] = '{32'hFFFF_FFFF, 32'h0010_0000, 32'hFFFF_FFFF, 1'b0};
        vecs[3] = '{32'h7D00_0000, 32'h0080_0000, 32'h7FFF_FFFF, 1'b1};
        vecs[4] = '{32'h8300_0000, 32'h0080_0000, 32'h8000_0000, 1'b1};
        vecs[5] = '{32'h0060_0000, 32'hFFB0_0000, 32'hFF10_0000, 1'b0};
        vecs[6] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1};
        ident   = '{32'h0030_0000, 32'h0, 32'hFFC0_0000, 32'h0,
                    32'h0, 32'h0008_0000, 32'h0, 32'h0060_0000};

        for (int n = 0; n < N*N; n++) begin
            a_m[n] = '0;
            b_m[n] = '0;
        end
        bus.load_we   = 1'b0;
        bus.load_sel  = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        bus.start     = 1'b0;

        #12;
        check("rst_prod", bus.prod, 0);
        check("rst_pv", bus.prod_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_sat", bus.sat, 0);
        check("rst_row", bus.row_idx, 0);
        check("rst_col", bus.col_idx, 0);
        @(negedge clk);
        rst = 1'b1;

        // Identity times B.
        load(1'b0, 0, 32'h0020_0000);
        load(1'b0, 3, 32'h0020_0000);
        load(1'b1, 0, 32'h0030_0000);
        load(1'b1, 1, 32'hFFC0_0000);
        load(1'b1, 2, 32'h0008_0000);
        load(1'b1, 3, 32'h0060_0000);
        push_list(ident);
        run(1'b0);
        check("ident_sat", bus.sat, 0);

        // Single-product vectors: only A[0][0] and B[0][0] are non-zero.
        clear_ops();
        for (int v = 0; v < 7; v++) begin
            load(1'b0, 0, vecs[v].a);
            load(1'b1, 0, vecs[v].b);
            for (int n = 0; n < NP; n++) single[n] = (n == 0) ? vecs[v].exp_prod : 32'h0;
            push_list(single);
            run(1'b0);
            check($sformatf("vec%0d_sat", v), bus.sat, vecs[v].exp_sat);
        end

        // Writes and starts while busy must change nothing.
        load(1'b0, 0, 32'h0018_0000);
        load(1'b0, 1, 32'hFFF0_0000);
        load(1'b0, 2, 32'h0040_0000);
        load(1'b0, 3, 32'h0002_0000);
        load(1'b1, 0, 32'h0020_0000);
        load(1'b1, 1, 32'h00A0_0000);
        load(1'b1, 2, 32'hFFC0_0000);
        load(1'b1, 3, 32'h0010_0000);
        push_model();
        run(1'b1);
        push_model();
        run(1'b0);

        // Reset during the third product.
        clear_ops();
        load(1'b0, 0, 32'h7D00_0000);
        load(1'b1, 0, 32'h0080_0000);
        load(1'b1, 1, 32'h0010_0000);
        push_model();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        check("mid_pv", bus.prod_valid, 1);
        check("mid_sat", bus.sat, 1);
        rst = 1'b0;
        #1;
        check("arst_prod", bus.prod, 0);
        check("arst_pv", bus.prod_valid, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_done", bus.done, 0);
        check("arst_sat", bus.sat, 0);
        check("arst_row", bus.row_idx, 0);
        check("arst_col", bus.col_idx, 0);
        sb.delete();
        for (int n = 0; n < N*N; n++) begin
            a_m[n] = '0;
            b_m[n] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk);
            #1;
            check("post_rst_done", bus.done, 0);
            check("post_rst_busy", bus.busy, 0);
        end
        push_model();
        run(1'b0);
        load(1'b0, 0, 32'h7D00_0000);
        load(1'b1, 0, 32'h0080_0000);
        load(1'b1, 1, 32'h0010_0000);
        push_model();
        run(1'b0);
        check("rerun_sat", bus.sat, 1);

        check("sb_final", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/matmul_prod_seq.md
Name: matmul_prod_seq

Overview:
- Operand store and product sequencer for the small fixed-point matrix multiplier.
- Holds matrices A and B, each N x N, in Q11.21 format: 32-bit signed, 11 integer bits including sign, 21 fraction bits.
- For each result element C[i][j], row-major, it issues the N products A[i][k]*B[k][j] on prod/prod_valid.
- prod_valid drives the downstream 2-term accumulator's ena and prod drives its data. The accumulator emits C[i][j] with its flag after every N products.

Parameters:
- N, 2, matrix dimension. Must equal the number of terms the downstream accumulator sums; that accumulator is fixed at 2.
- AW, 1, index width, equal to clog2(N).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- load_we  in  1  operand write strobe.
- load_sel  in  1  write target: 0 = matrix A, 1 = matrix B.
- load_addr  in  2*AW  element address {row, col}, with row in the MSBs.
- load_data  in  32  Q11.21 operand value.
- start  in  1  single-cycle pulse that begins a multiply run.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at the end of a run.
- prod  out  32  Q11.21 saturated product; connects to the accumulator's data input.
- prod_valid  out  1  product qualifier; connects to the accumulator's ena input.
- row_idx  out  AW  i of the C element that the current product belongs to.
- col_idx  out  AW  j of the C element that the current product belongs to.
- sat  out  1  sticky flag: some product in the current run saturated.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - All A and B entries are cleared to 0.
  - prod, prod_valid, busy, done, sat, row_idx, col_idx and all counters are cleared to 0.
  - Reset asserted mid-run aborts the run immediately; no done pulse is produced.
- Loading:
  - When load_we=1 and busy=0, load_data is written on the clock edge to A or B at load_addr.
  - When busy=1, load_we is ignored.
- States and transitions:
  - IDLE: if start=1, go to RUN and set i=j=k=0, clear sat, set busy=1.
  - RUN: each cycle registers prod = sat(A[i][k]*B[k][j]) and sets prod_valid=1, with row_idx=i and col_idx=j.
    - If k<N-1, increment k and stay in RUN.
    - If k=N-1, go to GAP.
  - GAP: exactly one cycle with prod_valid=0.
    - This gives the accumulator the cycle it needs to clear after its flag.
    - The GAP is mandatory, because the accumulator drops data presented during its clear cycle.
    - Then set k=0 and advance (i,j) row-major: j increments, wraps to 0, then i increments.
    - If (i,j) was the last element (N-1,N-1), go to DONE; otherwise go to RUN.
  - DONE: done=1 for one cycle, busy goes to 0, then go to IDLE.
  - start is ignored in every state except IDLE.
- Latency and output pattern:
  - prod_valid first asserts on the output one clock after the edge that samples start.
  - The prod_valid pattern is (N ones, then one zero), repeated N*N times.
  - done asserts on the cycle after the final GAP.
  - For N=2: the run lasts 12 cycles, followed by the 1-cycle done pulse.
- Arithmetic:
  - The full product is 64-bit signed (Q22.42).
  - It is arithmetic-shifted right by 21 to keep bits [52:21], truncating toward minus infinity.
  - If bits [63:52] are not all equal to bit 52, the result saturates:
    - to 0x7FFF_FFFF if the product is positive;
    - to 0x8000_0000 if the product is negative.
  - Any saturation sets sat=1. sat holds until the next accepted start or until reset.
- Between runs:
  - prod holds its last value while prod_valid=0.
  - row_idx and col_idx hold their last values in IDLE.

Test Plan:
- Identity times B:
  - Stimulus: load A=I (1.0 = 0x0020_0000 on the diagonal, 0 elsewhere) and B = {1.5, -2.0; 0.25, 3.0}, then pulse start.
  - Response: products 0x0030_0000, 0, 0xFFC0_0000, 0, 0, 0x0008_0000, 0, 0x0060_0000.
  - Index pairs (i,j) are (0,0),(0,1),(1,0),(1,1), with two products each.
- Timing:
  - Stimulus: start sampled at edge E0.
  - Response: prod_valid is high after E1 and E2, low after E3, and so on for 12 cycles. done is high for exactly the cycle after E12, and busy is low after E13.
- Sign and truncation:
  - Stimulus: -1.0 (0xFFE0_0000) times 0.5 (0x0010_0000).
  - Response: 0xFFF0_0000.
  - Stimulus: 2^-21 times 0.5.
  - Response: 0 (truncated). -2^-21 times 0.5 gives 0xFFFF_FFFF.
- Saturation:
  - Stimulus: 1000.0 times 4.0.
  - Response: 0x7FFF_FFFF and sat=1.
  - Stimulus: -1000.0 times 4.0.
  - Response: 0x8000_0000.
  - The next start clears sat.
- Protection:
  - Stimulus: load_we asserted and a second start pulsed while busy=1.
  - Response: operands are unchanged and the run sequence is unaffected.
- Reset mid-run:
  - Stimulus: rst low during the third product.
  - Response: all outputs are 0 immediately, there is no done pulse, and after release a rerun with reloaded operands gives the correct results.
- Co-simulation with the accumulator:
  - Response: the accumulator's flag pulses 4 times, and the accumulated values equal the row/column dot products.
